// File: rtl/adc_serial_capture_pkg.sv
// Shared types and elaboration helpers for adc_serial_capture: FSM states and frame sizing.
package adc_serial_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } adc_state_t;

  function automatic int unsigned frame_bits(input int unsigned lead_bits,
                                             input int unsigned data_w);
    return lead_bits + data_w;
  endfunction

  // Shortest legal period: one full frame plus the DONE and IDLE cycles.
  function automatic int unsigned min_sample_period(input int unsigned clk_div,
                                                    input int unsigned n_bits);
    return 2 * clk_div * n_bits + 2;
  endfunction

endpackage

// File: rtl/adc_serial_capture_sclk_gen.sv
// Serial clock generator for adc_serial_capture: CLK_DIV divider, rise/fall strobes,
// bit counter and end-of-frame flag. adc_clk idles high whenever active is low.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          active,
  output logic                          adc_clk,
  output logic                          rise,
  output logic                          fall,
  output logic [$clog2(FRAME_BITS)-1:0] bit_idx,
  output logic                          frame_end
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_hi;
  logic             last_div;

  assign last_div = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || start) begin
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_idx  <= '0;
    end else if (active) begin
      if (last_div) begin
        div_cnt  <= '0;
        phase_hi <= !phase_hi;
        if (phase_hi) begin
          bit_idx <= bit_idx + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Strobes mark the first cycle of each phase, i.e. the cycle the pin changes level.
  assign adc_clk   = !active || phase_hi;
  assign rise      = active && phase_hi && (div_cnt == '0);
  assign fall      = active && !phase_hi && (div_cnt == '0);
  assign frame_end = active && phase_hi && last_div && (bit_idx == BIT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/adc_serial_capture.sv
// Master for ADCS7476-style serial ADCs: periodic frames, N parallel data lines, valid/ready output.
// Optional `ADC_AVG_EN: offer the mean of every 2^AVG_LOG2 frames instead of each raw frame.
module adc_serial_capture
  import adc_serial_capture_pkg::*;
#(
  parameter int unsigned DATA_W        = 12,
  parameter int unsigned LEAD_BITS     = 4,
  parameter int unsigned CHANNELS      = 1,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 20000,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         adc_cs,
  output logic                         adc_clk,
  input  logic [CHANNELS-1:0]          adc_sd,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic                         busy
);

  localparam int unsigned FRAME_BITS = frame_bits(LEAD_BITS, DATA_W);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
  localparam int unsigned PER_W      = $clog2(SAMPLE_PERIOD);

  if (CLK_DIV < 1 || AVG_LOG2 > 16 ||
      SAMPLE_PERIOD < min_sample_period(CLK_DIV, FRAME_BITS)) begin : g_param_check
    $error("adc_serial_capture: CLK_DIV, AVG_LOG2 or SAMPLE_PERIOD out of range");
  end

  adc_state_t       state, state_next;
  logic             start, active, frame_done;
  logic             rise, fall, frame_end;
  logic [BIT_W-1:0] bit_idx;
  logic [PER_W-1:0] period_cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      period_cnt <= '0;
    end else if (period_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && period_cnt == '0) begin
          state_next = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT:   if (frame_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign active     = (state == SHIFT);
  assign frame_done = (state == DONE);
  assign adc_cs     = !active;
  assign busy       = active;

  adc_sclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .active    (active),
    .adc_clk   (adc_clk),
    .rise      (rise),
    .fall      (fall),
    .bit_idx   (bit_idx),
    .frame_end (frame_end)
  );

  logic [DATA_W-1:0]          shift_q [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] frame_data;

  // Shift registers clear at the first falling edge so an aborted frame leaves nothing behind.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (fall && bit_idx == '0) begin
        shift_q[c] <= '0;
      end else if (rise && bit_idx >= BIT_W'(LEAD_BITS)) begin
        shift_q[c] <= {shift_q[c][DATA_W-2:0], adc_sd[c]};
      end
    end
  end

  always_comb begin
    frame_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      frame_data[c*DATA_W +: DATA_W] = shift_q[c];
    end
  end

  logic                       offer;
  logic [CHANNELS*DATA_W-1:0] offer_data;

`ifdef ADC_AVG_EN
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic [SUM_W-1:0]    acc_q   [CHANNELS];
  logic [SUM_W-1:0]    acc_sum [CHANNELS];
  logic [AVG_LOG2-1:0] frame_cnt;

  always_comb begin
    offer      = frame_done && (frame_cnt == '1);
    offer_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      acc_sum[c] = acc_q[c] + SUM_W'(frame_data[c*DATA_W +: DATA_W]);
      offer_data[c*DATA_W +: DATA_W] = acc_sum[c][SUM_W-1:AVG_LOG2];
    end
  end

  // Disabling only clears once idle, so a frame already in flight still accumulates.
  always_ff @(posedge clk) begin
    if (reset || (!enable && state == IDLE)) begin
      frame_cnt <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= offer ? '0 : acc_sum[c];
    end
  end
`else
  assign offer      = frame_done;
  assign offer_data = frame_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else if (offer) begin
      if (!out_valid || out_ready) begin
        out_data  <= offer_data;
        out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: per-channel ADC pin models, a frame-level output model checked
// every cycle, and directed scenarios with literal expectations. Define ADC_AVG_EN for the averaging run.
module tb_adc_serial_capture;

  localparam int DATA_W        = 12;
  localparam int LEAD_BITS     = 4;
  localparam int CHANNELS      = 2;
  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
  localparam int AVG_LOG2      = 2;
  localparam int FRAME_LOW     = 2 * CLK_DIV * (LEAD_BITS + DATA_W);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic out_ready = 1'b0;
  logic adc_cs, adc_clk, out_valid, overrun, busy;
  logic [CHANNELS-1:0] adc_sd = '0;
  logic [CHANNELS*DATA_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_serial_capture #(
    .DATA_W        (DATA_W),
    .LEAD_BITS     (LEAD_BITS),
    .CHANNELS      (CHANNELS),
    .CLK_DIV       (CLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .AVG_LOG2      (AVG_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .adc_cs    (adc_cs),
    .adc_clk   (adc_clk),
    .adc_sd    (adc_sd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ADC pins: bit k of a frame appears after the k-th sclk fall (first fall coincides with cs fall).
  logic [DATA_W-1:0] val [CHANNELS];
  logic [DATA_W-1:0] cur [CHANNELS];
  int  adc_bit = -1;
  logic adc_prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (adc_cs) begin
      adc_bit = -1;
    end else if (adc_prev_sclk && !adc_clk) begin
      adc_bit++;
      if (adc_bit == 0) for (int c = 0; c < CHANNELS; c++) cur[c] = val[c];
      for (int c = 0; c < CHANNELS; c++)
        adc_sd[c] = (adc_bit < LEAD_BITS) ? 1'b0 : cur[c][DATA_W-1-(adc_bit-LEAD_BITS)];
    end
    adc_prev_sclk = adc_clk;
  end

  // Output model: a full-length frame yields the values the ADC models sent; handshake rules applied.
  logic m_valid = 1'b0;
  logic m_ovr = 1'b0;
  logic [CHANNELS*DATA_W-1:0] m_data = '0;
  int  low_run = 0;
  int  avg_n = 0;
  int  avg_sum [CHANNELS];
  logic armed = 1'b0;

  always @(posedge clk) begin
    logic m_offer;
    logic [CHANNELS*DATA_W-1:0] res;
    m_offer = 1'b0;
    res = '0;
    if (reset) begin
      armed = 1'b1;
      m_valid = 1'b0;
      m_data = '0;
      m_ovr = 1'b0;
      low_run = 0;
      avg_n = 0;
      for (int c = 0; c < CHANNELS; c++) avg_sum[c] = 0;
    end else begin
      if (adc_cs && low_run == FRAME_LOW) begin
`ifdef ADC_AVG_EN
        avg_n++;
        for (int c = 0; c < CHANNELS; c++) avg_sum[c] += int'(cur[c]);
        if (avg_n == (1 << AVG_LOG2)) begin
          m_offer = 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            res[c*DATA_W +: DATA_W] = DATA_W'(avg_sum[c] / (1 << AVG_LOG2));
            avg_sum[c] = 0;
          end
          avg_n = 0;
        end
`else
        m_offer = 1'b1;
        for (int c = 0; c < CHANNELS; c++) res[c*DATA_W +: DATA_W] = cur[c];
`endif
      end
      if (m_offer) begin
        if (!m_valid || out_ready) begin
          m_data = res;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      low_run = adc_cs ? 0 : low_run + 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), 64'(m_data));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("busy", 64'(busy), 64'(!adc_cs));
    end
  end

  // Pin monitor: frame length, sclk rises, frame start spacing, delivered results.
  int  cyc = 0, low_cnt = 0, rise_cnt = 0, last_len = 0, last_rises = 0;
  int  start_cyc = 0, prev_start = 0, cs_falls = 0, valid_cycles = 0;
  logic mon_cs = 1'b1, mon_sclk = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!adc_cs) begin
      if (mon_cs) begin
        prev_start = start_cyc;
        start_cyc = cyc;
        cs_falls++;
        low_cnt = 0;
        rise_cnt = 0;
      end
      low_cnt++;
      if (!mon_sclk && adc_clk) rise_cnt++;
    end else if (!mon_cs) begin
      last_len = low_cnt;
      last_rises = rise_cnt;
    end
    if (out_valid) valid_cycles++;
    mon_cs = adc_cs;
    mon_sclk = adc_clk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cs(input logic level, input int budget, input string name);
    int n = 0;
    while (adc_cs !== level && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(adc_cs === level), 64'd1);
  endtask

  task automatic wait_rises(input int count, input int budget, input string name);
    int n = 0;
    while (rise_cnt < count && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(rise_cnt), 64'(count));
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int v0, f0;
    val[0] = 12'hABC;
    val[1] = 12'h123;
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;

    // Reset held with enable high: all outputs at idle values.
    repeat (5) begin
      tick();
      check("rst_cs", 64'(adc_cs), 64'd1);
      check("rst_sclk", 64'(adc_clk), 64'd1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
    end
    reset = 1'b0;

`ifdef ADC_AVG_EN
    begin
      logic [DATA_W-1:0] seq [4];
      seq[0] = 12'd100; seq[1] = 12'd101; seq[2] = 12'd102; seq[3] = 12'd104;
      val[0] = seq[0];
      val[1] = 12'd8;
      for (int f = 0; f < 4; f++) begin
        wait_cs(1'b0, 110, "avg_frame_start");
        wait_cs(1'b1, 80, "avg_frame_end");
        if (f < 3) begin
          val[0] = seq[f+1];
          repeat (3) tick();
          check("avg_no_valid", 64'(valid_cycles), 64'd0);
        end
      end
      wait_valid(5, "avg_valid_wait");
      check("avg_ch0", 64'(out_data[11:0]), 64'd101);
      check("avg_ch1", 64'(out_data[23:12]), 64'd8);
      tick();
      check("avg_valid_pulse", 64'(out_valid), 64'd0);
    end
`else
    // Basic frame: 64 cs-low cycles, 16 rises, one-cycle result, 100-cycle frame spacing.
    wait_cs(1'b0, 10, "first_frame_start");
    wait_cs(1'b1, 80, "first_frame_end");
    check("frame_len", 64'(last_len), 64'd64);
    check("frame_rises", 64'(last_rises), 64'd16);
    wait_valid(5, "first_valid_wait");
    check("first_data", 64'(out_data), 64'h123ABC);
    tick();
    check("valid_pulse", 64'(out_valid), 64'd0);
    wait_cs(1'b0, 100, "second_frame_start");
    check("frame_spacing", 64'(start_cyc - prev_start), 64'd100);

    // Consumer stalled across two frames: the second result is dropped and overrun sticks.
    out_ready = 1'b0;
    wait_cs(1'b1, 80, "stall_frame1_end");
    val[0] = 12'h555;
    val[1] = 12'h555;
    wait_valid(5, "stall_valid_wait");
    check("stall_data1", 64'(out_data), 64'h123ABC);
    wait_cs(1'b0, 100, "stall_frame2_start");
    wait_cs(1'b1, 80, "stall_frame2_end");
    repeat (3) tick();
    check("stall_data2", 64'(out_data), 64'h123ABC);
    check("stall_overrun", 64'(overrun), 64'd1);
    check("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("ready_drops_valid", 64'(out_valid), 64'd0);

    // Reset at the 7th sclk rise: frame aborted, nothing delivered, next frame complete.
    wait_cs(1'b0, 110, "abort_frame_start");
    wait_rises(7, 64, "abort_rise7");
    v0 = valid_cycles;
    reset = 1'b1;
    tick();
    check("abort_cs_high", 64'(adc_cs), 64'd1);
    check("abort_overrun_clr", 64'(overrun), 64'd0);
    reset = 1'b0;
    wait_cs(1'b0, 10, "post_reset_start");
    wait_cs(1'b1, 80, "post_reset_end");
    check("post_reset_len", 64'(last_len), 64'd64);
    check("post_reset_rises", 64'(last_rises), 64'd16);
    check("abort_no_valid", 64'(valid_cycles), 64'(v0));
    wait_valid(5, "post_reset_valid_wait");
    check("post_reset_data", 64'(out_data), 64'h555555);

    // Enable dropped at the 3rd rise: frame still delivered, then no further frames.
    val[0] = 12'h7E1;
    val[1] = 12'h03C;
    wait_cs(1'b0, 110, "last_frame_start");
    wait_rises(3, 64, "last_rise3");
    enable = 1'b0;
    wait_cs(1'b1, 80, "last_frame_end");
    check("last_len", 64'(last_len), 64'd64);
    wait_valid(5, "last_valid_wait");
    check("last_data", 64'(out_data), 64'h03C7E1);
    f0 = cs_falls;
    repeat (300) tick();
    check("no_new_frames", 64'(cs_falls), 64'(f0));
    check("idle_cs", 64'(adc_cs), 64'd1);
    check("idle_sclk", 64'(adc_clk), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
